// File: rtl/if_id_latch_pkg.sv
// Shared constants, state encoding and opcode helper for the IF/ID pipeline register.
// Decode and control import the same package so the HALT/NOP encodings live in one place.
package if_id_latch_pkg;

  localparam int              WIDTH     = 16;
  localparam int              OPC_W     = 5;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00001;
  localparam logic [WIDTH-1:0] NOP_INSTR = 16'h0800;
  localparam logic [OPC_W-1:0] HALT_OPC = OPC_HALT;

  // The halted flop is the whole state machine: 0 = RUN, 1 = HALTED.
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  function automatic logic [OPC_W-1:0] opcode(input logic [WIDTH-1:0] instr);
    return instr[WIDTH-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/if_id_latch_if.sv
// Fetch-to-decode bundle: fetch data and hazard controls in, decode-side payload out.
// master drives the fetch side; slave is the pipeline register itself.
interface if_id_latch_if
  import if_id_latch_pkg::*;
();

  logic [WIDTH-1:0] instr_in;
  logic [WIDTH-1:0] incPC_in;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] instr_out;
  logic [WIDTH-1:0] incPC_out;
  logic             valid_out;
  logic             halted;
  logic             fetch_hold;

  modport master (
    output instr_in, incPC_in, stall, flush,
    input  instr_out, incPC_out, valid_out, halted, fetch_hold
  );

  modport slave (
    input  instr_in, incPC_in, stall, flush,
    output instr_out, incPC_out, valid_out, halted, fetch_hold
  );

endinterface

// File: rtl/if_id_latch_reg.sv
// Generic register cell with synchronous reset to zero and a write enable.
// Latency one cycle; holds its value whenever we is low.
module if_id_latch_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] data_d,
  output logic [W-1:0] data_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (we) begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/if_id_latch.sv
// IF/ID register: one-cycle capture of instruction and PC+2 with flush > halt > stall > load.
// Backpressure: stall or a latched HALT freezes the slot and drives fetch_hold straight back to fetch.
module if_id_latch
  import if_id_latch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  if_id_latch_if.slave  bus
);

  logic [WIDTH-1:0] instr_d, instr_q;
  logic [WIDTH-1:0] pc_d, pc_q;
  logic             valid_d, valid_q;
  state_e           state_d, state_q;
  logic [0:0]       state_raw_q;

  assign state_q = state_e'(state_raw_q);

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    state_d = state_q;
    if (bus.flush) begin
      // A redirect also cancels a HALT fetched down the wrong path.
      instr_d = NOP_INSTR;
      pc_d    = bus.incPC_in;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_HALTED || bus.stall) begin
      instr_d = instr_q;
    end else begin
      instr_d = bus.instr_in;
      pc_d    = bus.incPC_in;
      valid_d = 1'b1;
      state_d = (opcode(bus.instr_in) == HALT_OPC) ? ST_HALTED : ST_RUN;
    end
  end

  if_id_latch_reg #(.W(WIDTH)) u_instr_reg (
    .clk(clk), .rst(rst), .we(1'b1), .data_d(instr_d), .data_q(instr_q)
  );

  if_id_latch_reg #(.W(WIDTH)) u_pc_reg (
    .clk(clk), .rst(rst), .we(1'b1), .data_d(pc_d), .data_q(pc_q)
  );

  if_id_latch_reg #(.W(1)) u_valid_reg (
    .clk(clk), .rst(rst), .we(1'b1), .data_d(valid_d), .data_q(valid_q)
  );

  if_id_latch_reg #(.W(1)) u_halted_reg (
    .clk(clk), .rst(rst), .we(1'b1), .data_d(state_d), .data_q(state_raw_q)
  );

  // Register resets to zero, so the bubble is produced here rather than by the reset value.
  assign bus.instr_out  = valid_q ? instr_q : NOP_INSTR;
  assign bus.incPC_out  = pc_q;
  assign bus.valid_out  = valid_q;
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.fetch_hold = bus.stall | (state_q == ST_HALTED);

endmodule

// File: tb/tb_if_id_latch.sv
// Randomised and directed stimulus against a queue-based scoreboard for if_id_latch.
// The driver predicts each post-edge output; an independent monitor pops and compares.
module tb_if_id_latch;

  logic clk;
  logic rst;

  if_id_latch_if bus ();

  if_id_latch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        halted;
    logic        hold;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   driver_done = 1'b0;

  // Reference state: what decode should see after the next edge.
  logic [15:0] m_instr = 16'h0800;
  logic [15:0] m_pc    = 16'h0000;
  logic        m_valid = 1'b0;
  logic        m_halted = 1'b0;

  task automatic cyc(input logic r, input logic s, input logic f,
                     input logic [15:0] i, input logic [15:0] p);
    obs_t e;
    @(negedge clk);
    rst          = r;
    bus.stall    = s;
    bus.flush    = f;
    bus.instr_in = i;
    bus.incPC_in = p;
    if (r) begin
      m_instr = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (f) begin
      m_instr = 16'h0800; m_pc = p; m_valid = 1'b0; m_halted = 1'b0;
    end else if (!m_halted && !s) begin
      m_instr = i; m_pc = p; m_valid = 1'b1; m_halted = (i >> 11) == 0;
    end
    e.instr  = m_instr;
    e.pc     = m_pc;
    e.valid  = m_valid;
    e.halted = m_halted;
    e.hold   = s | m_halted;
    exp_q.push_back(e);
  endtask

  // Monitor: samples one time unit after each active edge.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.instr_out, bus.incPC_out, bus.valid_out, bus.halted, bus.fetch_hold};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL out t=%0t got instr=%h pc=%h v=%b h=%b hold=%b want instr=%h pc=%h v=%b h=%b hold=%b",
                   $time, a.instr, a.pc, a.valid, a.halted, a.hold,
                   e.instr, e.pc, e.valid, e.halted, e.hold);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ri;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.instr_in = 16'h0000;
    bus.incPC_in = 16'h0000;

    // Reset, then idle release with a real instruction stream.
    cyc(1, 0, 0, 16'h1234, 16'h1111);
    cyc(1, 0, 0, 16'h0000, 16'h2222);
    cyc(0, 0, 0, 16'h4123, 16'h0002);
    cyc(0, 0, 0, 16'h4567, 16'h0004);
    // Stall holds while inputs move.
    cyc(0, 1, 0, 16'h4AAA, 16'h0006);
    cyc(0, 1, 0, 16'h4BBB, 16'h0008);
    cyc(0, 1, 0, 16'h4CCC, 16'h000A);
    cyc(0, 0, 0, 16'h4DDD, 16'h000C);
    // Flush beats stall.
    cyc(0, 1, 1, 16'h6ABC, 16'h000E);
    // HALT latches and ignores later fetches, flush releases it.
    cyc(0, 0, 0, 16'h0000, 16'h0010);
    cyc(0, 0, 0, 16'h4111, 16'h0012);
    cyc(0, 1, 0, 16'h4222, 16'h0014);
    cyc(0, 0, 1, 16'h4333, 16'h0016);
    // Reset while halted, then PC wrap.
    cyc(0, 0, 0, 16'h07FF, 16'h0018);
    cyc(1, 0, 0, 16'h4444, 16'h001A);
    cyc(0, 0, 0, 16'h4555, 16'hFFFE);
    cyc(0, 0, 0, 16'h4666, 16'h0000);

    for (int n = 0; n < 600; n++) begin
      ri = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ri[15:11] = 5'b00000;
      if ($urandom_range(0, 9) == 0) ri = 16'h0800;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, ri, 16'($urandom));
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    driver_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
